serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor: the borrow-propagating counterpart to the team's half-adder arithmetic cells, computing d = a - b one bit per clock, LSB first, with a single borrow flip-flop. Accepts operands on a start pulse, streams difference bits out serially, and presents the full parallel difference plus final borrow on completion. Intended for area-constrained datapaths where a ripple subtractor per lane is too costly.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; d and bout valid
d  output  WIDTH  parallel difference (a - b) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b unsigned
ser_bit  output  1  current serial difference bit
ser_valid  output  1  ser_bit qualifier

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, d, bout, ser_bit, ser_valid all 0; internal shift regs, borrow, counter cleared. Reset asserted mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE. All outputs registered.
- IDLE: start=1 at edge E0 -> capture a into ra and b into rb, borrow br=0, cnt=0, go to RUN; busy=1 from E0. start=0 -> stay.
- RUN, edges E1..EWIDTH (one per bit, n = cnt):
  - diff = ra[0] ^ rb[0] ^ br
  - br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
  - ra, rb shift right by 1; diff shifts into MSB of the result register (after WIDTH shifts, bit i = diff of bit i).
  - ser_bit = diff, ser_valid = 1; cnt increments.
  - At EWIDTH: d = final result register, bout = br_next, done=1, busy=0, go to DONE.
- DONE (one cycle): at next edge done=0, ser_valid=0, go to IDLE. d and bout hold until the next accepted start's completion (not cleared on start).
- Latency: done is high in the cycle following edge E(WIDTH), i.e., WIDTH clock edges after the accepting edge. Throughput: one operation per WIDTH+2 cycles (start is sampled in IDLE only).
- ser_valid is high for exactly WIDTH consecutive cycles; its last cycle coincides with done.
- start while in RUN or DONE: ignored; no queuing, no effect on the in-flight operation.
- a and b changes after capture have no effect.
- Arithmetic: unsigned modulo 2^WIDTH; bout is the final borrow. For signed use, the caller derives overflow externally.
- WIDTH=1: RUN lasts one edge; d = a ^ b; bout = ~a & b.
- Counter width: enough bits to hold WIDTH; no wrap occurs within an operation.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, start pulse -> busy for 8 cycles; done with d=0x37, bout=0; ser_bit sequence LSB-first 1,1,1,0,1,1,0,0.
- a=0x23, b=0x5A -> d=0xC9, bout=1. a=0x00, b=0x01 -> d=0xFF, bout=1 (full borrow ripple).
- a=0xFF, b=0xFF -> d=0x00, bout=0. a=0x80, b=0x00 -> d=0x80, bout=0.
- Hold start high continuously with changing a/b -> operations start only from IDLE, spaced 10 cycles apart. Each result matches the operands present at its accepting edge. Mid-RUN operand changes are ignored.
- Assert rst at bit 4 of an operation -> busy, ser_valid, d, bout drop to 0 immediately (asynchronous). No done is produced. After release, a new start with a=0x10, b=0x01 gives d=0x0F, bout=0.
- WIDTH=1 build: all four (a,b) combinations -> d/bout equal to 0/0, 1/0, 1/1, 0/0 for (0,0), (1,0), (0,1), (1,1). done is one edge after acceptance.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor.
// Computes d = a - b one bit per clock, LSB first, with a single borrow
// flip-flop. The serial difference bits stream out on ser_bit/ser_valid.
// The full parallel difference and the final borrow are presented with a
// one-cycle done pulse when the operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ser_bit,
    output logic             ser_valid
);

    // The counter only has to reach WIDTH-1. Sizing it for WIDTH keeps it at
    // least one bit wide when WIDTH is 1.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shiftA_q;
    logic [WIDTH-1:0] shiftB_q;
    logic [WIDTH-1:0] result_q;
    logic             borrow_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diffOut_q;
    logic             borrowOut_q;
    logic             serBit_q;
    logic             serValid_q;

    logic             diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] result_d;

    // One full-subtractor cell working on the current LSBs. The new difference
    // bit enters the result register at the MSB, so after WIDTH shifts bit i
    // holds the difference of operand bit i.
    always_comb begin
        diff_d   = shiftA_q[0] ^ shiftB_q[0] ^ borrow_q;
        borrow_d = (~shiftA_q[0] & shiftB_q[0]) |
                   (~(shiftA_q[0] ^ shiftB_q[0]) & borrow_q);
        result_d = result_q >> 1;
        result_d[WIDTH-1] = diff_d;
    end

    // Control FSM and datapath registers. Every output is registered here.
    // Reset clears everything, which also aborts an operation in flight
    // without producing a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shiftA_q    <= '0;
            shiftB_q    <= '0;
            result_q    <= '0;
            borrow_q    <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            diffOut_q   <= '0;
            borrowOut_q <= 1'b0;
            serBit_q    <= 1'b0;
            serValid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q     <= 1'b0;
                    serValid_q <= 1'b0;
                    if (start) begin
                        shiftA_q <= a;
                        shiftB_q <= b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    shiftA_q   <= shiftA_q >> 1;
                    shiftB_q   <= shiftB_q >> 1;
                    borrow_q   <= borrow_d;
                    result_q   <= result_d;
                    serBit_q   <= diff_d;
                    serValid_q <= 1'b1;
                    count_q    <= count_q + CNT_W'(1);
                    if (count_q == LAST_BIT) begin
                        diffOut_q   <= result_d;
                        borrowOut_q <= borrow_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    serValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign d         = diffOut_q;
    assign bout      = borrowOut_q;
    assign ser_bit   = serBit_q;
    assign ser_valid = serValid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor. An 8-bit instance and a 1-bit instance
// share one clock. Expected results come from plain unsigned arithmetic:
// d = (a - b) mod 2^WIDTH, bout = (a < b), and the serial bits are the bits
// of d, LSB first.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bout8;
    logic       serBit8;
    logic       serValid8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] d1;
    logic       bout1;
    logic       serBit1;
    logic       serValid1;

    int vectorCount;
    int missCount;

    logic [7:0] prevD;
    logic       prevBout;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .d         (d8),
        .bout      (bout8),
        .ser_bit   (serBit8),
        .ser_valid (serValid8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .d         (d1),
        .bout      (bout1),
        .ser_bit   (serBit1),
        .ser_valid (serValid1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full operation on the 8-bit instance, checked cycle by cycle.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB);
        logic [7:0] expD;
        logic       expBout;
        expD    = 8'(opA - opB);
        expBout = (opA < opB);
        @(negedge clk);
        a8     = opA;
        b8     = opB;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        checkOutput("busyAfterAccept", 32'(busy8), 32'd1);
        checkOutput("serValidAfterAccept", 32'(serValid8), 32'd0);
        checkOutput("dHeld", 32'(d8), 32'(prevD));
        checkOutput("boutHeld", 32'(bout8), 32'(prevBout));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checkOutput("serValid", 32'(serValid8), 32'd1);
            checkOutput("serBit", 32'(serBit8), 32'(expD[i]));
            checkOutput("busyRun", 32'(busy8), (i < 7) ? 32'd1 : 32'd0);
            checkOutput("doneRun", 32'(done8), (i == 7) ? 32'd1 : 32'd0);
        end
        checkOutput("d", 32'(d8), 32'(expD));
        checkOutput("bout", 32'(bout8), 32'(expBout));
        @(posedge clk);
        #1;
        checkOutput("doneDropped", 32'(done8), 32'd0);
        checkOutput("serValidDropped", 32'(serValid8), 32'd0);
        checkOutput("dAfterDone", 32'(d8), 32'(expD));
        prevD    = expD;
        prevBout = expBout;
    endtask

    // One operation on the 1-bit instance: done follows one edge after accept.
    task automatic applyStimulus1(input logic opA, input logic opB);
        logic expD;
        logic expBout;
        expD    = 1'(opA - opB);
        expBout = (opA < opB);
        @(negedge clk);
        a1[0]  = opA;
        b1[0]  = opB;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        checkOutput("w1Busy", 32'(busy1), 32'd1);
        checkOutput("w1DoneEarly", 32'(done1), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("w1Done", 32'(done1), 32'd1);
        checkOutput("w1Busy", 32'(busy1), 32'd0);
        checkOutput("w1D", 32'(d1), 32'(expD));
        checkOutput("w1Bout", 32'(bout1), 32'(expBout));
        checkOutput("w1SerBit", 32'(serBit1), 32'(expD));
        checkOutput("w1SerValid", 32'(serValid1), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("w1DoneDropped", 32'(done1), 32'd0);
    endtask

    // Start held high with operands changing every cycle. Accepts can only
    // happen from IDLE, so they land every 10 edges; each result must match
    // the operands present at its own accepting edge.
    task automatic runContinuous();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ea;
        logic [7:0] eb;
        @(negedge clk);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        start8 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            if (k % 10 == 0) begin
                qa.push_back(a8);
                qb.push_back(b8);
            end
            #1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (k == 29) start8 = 1'b0;
            checkOutput("contDone", 32'(done8), (k % 10 == 8) ? 32'd1 : 32'd0);
            checkOutput("contBusy", 32'(busy8), (k % 10 < 8) ? 32'd1 : 32'd0);
            if (k % 10 == 8) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                checkOutput("contD", 32'(d8), 32'(8'(ea - eb)));
                checkOutput("contBout", 32'(bout8), 32'(ea < eb));
                prevD    = 8'(ea - eb);
                prevBout = (ea < eb);
            end
        end
    endtask

    // Reset asserted while bit 4 is in progress must clear outputs at once
    // and suppress the done pulse of the aborted operation.
    task automatic runResetAbort();
        @(negedge clk);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abortBusy", 32'(busy8), 32'd0);
        checkOutput("abortSerValid", 32'(serValid8), 32'd0);
        checkOutput("abortD", 32'(d8), 32'd0);
        checkOutput("abortBout", 32'(bout8), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abortNoDone", 32'(done8), 32'd0);
        end
        prevD    = 8'h00;
        prevBout = 1'b0;
    endtask

    // Main sequence: reset state, directed vectors, random vectors,
    // continuous start, reset abort, then the 1-bit instance.
    initial begin
        vectorCount = 0;
        missCount   = 0;
        prevD       = 8'h00;
        prevBout    = 1'b0;
        rst         = 1'b1;
        start8      = 1'b0;
        a8          = 8'h00;
        b8          = 8'h00;
        start1      = 1'b0;
        a1          = 1'b0;
        b1          = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy8), 32'd0);
        checkOutput("rstDone", 32'(done8), 32'd0);
        checkOutput("rstD", 32'(d8), 32'd0);
        checkOutput("rstBout", 32'(bout8), 32'd0);
        checkOutput("rstSerBit", 32'(serBit8), 32'd0);
        checkOutput("rstSerValid", 32'(serValid8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h23);
        applyStimulus(8'h23, 8'h5A);
        applyStimulus(8'h00, 8'h01);
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'h80, 8'h00);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 8'($urandom));
        end

        runContinuous();
        runResetAbort();
        applyStimulus(8'h10, 8'h01);

        applyStimulus1(1'b0, 1'b0);
        applyStimulus1(1'b1, 1'b0);
        applyStimulus1(1'b0, 1'b1);
        applyStimulus1(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
